// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic phase controller.
package tlc_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2
    } tlc_state_e;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    function automatic int unsigned tlc_max3(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tlc_next_phase_arbiter.sv
// Combinational cyclic priority scan: first pending phase after cur_phase,
// cur_phase itself last; falls back to cur_phase+1 when nothing is pending.
module tlc_next_phase_arbiter
    import tlc_pkg::*;
#(
    parameter int unsigned NUM_PHASES = 4
) (
    input  logic [NUM_PHASES-1:0]         pending,
    input  logic [$clog2(NUM_PHASES)-1:0] cur_phase,
    output logic [$clog2(NUM_PHASES)-1:0] next_phase
);

    localparam int unsigned PW = $clog2(NUM_PHASES);

    logic [31:0] idx;
    logic        found;

    always_comb begin
        idx        = '0;
        found      = 1'b0;
        next_phase = (cur_phase == PW'(NUM_PHASES - 1)) ? '0 : cur_phase + 1'b1;
        for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
            idx = k + {{(32 - PW){1'b0}}, cur_phase};
            if (idx >= NUM_PHASES) begin
                idx = idx - NUM_PHASES;
            end
            if (!found && pending[idx[PW-1:0]]) begin
                found      = 1'b1;
                next_phase = idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// Multi-phase traffic signal controller: GREEN -> YELLOW -> ALLRED with sticky
// demand arbitration. Optional emergency preemption via TLC_EMERG_PREEMPT_EN.
module traffic_phase_controller
    import tlc_pkg::*;
#(
    parameter int unsigned NUM_PHASES   = 4,
    parameter int unsigned GREEN_TICKS  = 20,
    parameter int unsigned YELLOW_TICKS = 4,
    parameter int unsigned ALLRED_TICKS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PHASES-1:0]         demand,
    input  logic                          emerg_req,
    input  logic [$clog2(NUM_PHASES)-1:0] emerg_phase,
    output logic [3*NUM_PHASES-1:0]       lights,
    output logic [$clog2(NUM_PHASES)-1:0] cur_phase,
    output logic [1:0]                    state
);

    localparam int unsigned PW        = $clog2(NUM_PHASES);
    localparam int unsigned MAX_TICKS = tlc_max3(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS);
    localparam int unsigned CW        = $clog2(MAX_TICKS + 1);

    tlc_state_e              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           cur_phase_q, cur_phase_d;
    logic [NUM_PHASES-1:0]   pending_q, pending_d;
    logic [3*NUM_PHASES-1:0] lights_q, lights_d;

    logic [NUM_PHASES-1:0]   pending_merged;
    logic [PW-1:0]           arb_next;
    logic [PW-1:0]           sel_phase;
    logic                    emerg_ok;

    assign pending_merged = pending_q | demand;

    tlc_next_phase_arbiter #(
        .NUM_PHASES (NUM_PHASES)
    ) u_arb (
        .pending    (pending_merged),
        .cur_phase  (cur_phase_q),
        .next_phase (arb_next)
    );

`ifdef TLC_EMERG_PREEMPT_EN
    // Out-of-range emerg_phase (non power-of-two NUM_PHASES) is treated as no request.
    assign emerg_ok  = emerg_req && ({{(32 - PW){1'b0}}, emerg_phase} < NUM_PHASES);
    assign sel_phase = emerg_ok ? emerg_phase : arb_next;
`else
    logic unused_emerg;
    assign unused_emerg = ^{emerg_req, emerg_phase};
    assign emerg_ok     = 1'b0;
    assign sel_phase    = arb_next;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        cur_phase_d = cur_phase_q;
        pending_d   = pending_merged;

        unique case (state_q)
            GREEN: begin
                if (emerg_ok && (cur_phase_q != sel_phase)) begin
                    state_d = YELLOW;
                    cnt_d   = '0;
                end else if (emerg_ok) begin
                    // Held on the emergency phase; timing restarts on release.
                    cnt_d = '0;
                end else if (cnt_q == CW'(GREEN_TICKS - 1)) begin
                    state_d = YELLOW;
                    cnt_d   = '0;
                end
            end
            YELLOW: begin
                if (cnt_q == CW'(YELLOW_TICKS - 1)) begin
                    state_d = ALLRED;
                    cnt_d   = '0;
                end
            end
            ALLRED: begin
                if (cnt_q == CW'(ALLRED_TICKS - 1)) begin
                    state_d              = GREEN;
                    cnt_d                = '0;
                    cur_phase_d          = sel_phase;
                    pending_d[sel_phase] = demand[sel_phase];
                end
            end
            default: begin
                state_d = ALLRED;
                cnt_d   = '0;
            end
        endcase
    end

    // Lamps are derived from the next state so they register alongside it.
    always_comb begin
        lights_d = {NUM_PHASES{LAMP_RED}};
        for (int unsigned i = 0; i < NUM_PHASES; i++) begin
            if (PW'(i) == cur_phase_d) begin
                case (state_d)
                    GREEN:   lights_d[3*i +: 3] = LAMP_GREEN;
                    YELLOW:  lights_d[3*i +: 3] = LAMP_YELLOW;
                    default: lights_d[3*i +: 3] = LAMP_RED;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ALLRED;
            cnt_q       <= '0;
            cur_phase_q <= PW'(NUM_PHASES - 1);
            pending_q   <= '0;
            lights_q    <= {NUM_PHASES{LAMP_RED}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_phase_q <= cur_phase_d;
            pending_q   <= pending_d;
            lights_q    <= lights_d;
        end
    end

    assign lights    = lights_q;
    assign cur_phase = cur_phase_q;
    assign state     = state_q;

endmodule

// File: doc/traffic_phase_controller.md
TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 4, meaning number of signal phases (2..8).
REQ-002 SHALL have parameter GREEN_TICKS, default 20, meaning green duration in clk cycles (>=1).
REQ-003 SHALL have parameter YELLOW_TICKS, default 4, meaning yellow duration in clk cycles (>=1).
REQ-004 SHALL have parameter ALLRED_TICKS, default 2, meaning all-red clearance duration in clk cycles (>=1).
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, meaning synchronous active-low reset.
REQ-007 SHALL have port demand, input, NUM_PHASES bits, meaning per-phase vehicle/pedestrian request pulse.
REQ-008 SHALL have port emerg_req, input, 1 bit, meaning emergency preemption request (level).
REQ-009 SHALL have port emerg_phase, input, $clog2(NUM_PHASES) bits, meaning phase to preempt to.
REQ-010 SHALL have port lights, output, 3*NUM_PHASES bits, meaning per-phase lamp field {red,yellow,green}, phase i at bits [3i+2:3i].
REQ-011 SHALL have port cur_phase, output, $clog2(NUM_PHASES) bits, meaning the phase being served.
REQ-012 SHALL have port state, output, 2 bits, meaning FSM state (GREEN=0, YELLOW=1, ALLRED=2).

Function
REQ-013 SHALL use FSM GREEN -> YELLOW -> ALLRED -> GREEN, with a duration counter cleared on every state entry.
REQ-014 SHALL hold GREEN for exactly GREEN_TICKS cycles, YELLOW for YELLOW_TICKS, and ALLRED for ALLRED_TICKS.
REQ-015 SHALL drive 3'b001 for cur_phase in GREEN, 3'b010 in YELLOW, and 3'b100 for all phases in ALLRED; non-served phases SHALL always be 3'b100.
REQ-016 SHALL latch each demand bit into a sticky pending register, OR-ing new pulses.
REQ-017 SHALL clear the pending bit of a phase in the cycle that phase enters GREEN; a demand pulse on that same cycle SHALL win and remain pending.
REQ-018 SHALL select the next phase on ALLRED exit as the first pending phase scanning cyclically from cur_phase+1 (wrapping NUM_PHASES-1 -> 0, cur_phase itself checked last).
REQ-019 SHALL select (cur_phase+1) mod NUM_PHASES when no phase is pending.
REQ-020 SHALL be glitch-free: lights, cur_phase, and state are registered outputs.

Reset
REQ-021 SHALL, while rst=0 at a clk edge, set state=ALLRED, cur_phase=NUM_PHASES-1, counter=0, pending=0, and all lights=3'b100.
REQ-022 SHALL, on the first ALLRED exit after reset, enter GREEN on phase 0 when nothing is pending.
REQ-023 SHALL, on reset asserted mid-cycle in any state, force all-red on the next edge with no yellow.

Configuration
REQ-024 SHALL gate emergency preemption with macro TLC_EMERG_PREEMPT_EN.
REQ-025 SHALL, with TLC_EMERG_PREEMPT_EN defined and emerg_req=1 in GREEN on a phase other than emerg_phase, move to YELLOW on the next edge, then proceed through full ALLRED.
REQ-026 SHALL, with TLC_EMERG_PREEMPT_EN defined, make the ALLRED exit select emerg_phase when emerg_req=1, overriding pending.
REQ-027 SHALL, with TLC_EMERG_PREEMPT_EN defined, hold GREEN on emerg_phase while emerg_req=1, then run normal timing from its release.
REQ-028 SHALL, with TLC_EMERG_PREEMPT_EN defined, never truncate YELLOW or ALLRED on emerg_req.
REQ-029 SHALL, without TLC_EMERG_PREEMPT_EN, keep the emerg_req/emerg_phase ports but ignore them.

Structure
REQ-030 SHALL place in package tlc_pkg: the state enum (GREEN/YELLOW/ALLRED) and lamp constants LAMP_RED=3'b100, LAMP_YELLOW=3'b010, LAMP_GREEN=3'b001.
REQ-031 SHALL implement the cyclic next-pending scan as sub-module tlc_next_phase_arbiter (combinational priority rotate).

Verification (NUM_PHASES=4, GREEN=5, YELLOW=2, ALLRED=1)
REQ-032 SHALL cover: reset low 3 cycles then high, no demand -> all 3'b100 during reset; phase0 GREEN 5 cycles, YELLOW 2, ALLRED 1; then phase1, 2, 3, 0.
REQ-033 SHALL cover: demand=4'b1000 pulsed during phase0 GREEN -> next GREEN is phase3 (phases 1 and 2 skipped); pending[3] clears on entry.
REQ-034 SHALL cover: demand=4'b0110 pulsed during phase3 GREEN -> served in order 1, then 2, then cyclic 3.
REQ-035 SHALL cover: rst=0 asserted at GREEN cycle 3 of phase2 -> next edge all 3'b100, cur_phase=3, pending=0.
REQ-036 SHALL cover: with TLC_EMERG_PREEMPT_EN, emerg_req=1, emerg_phase=2 at GREEN cycle 1 of phase0 -> YELLOW next edge (2 cycles), ALLRED 1, then phase2 GREEN held until emerg_req=0, then 5 more cycles.
REQ-037 SHALL cover: the REQ-036 stimulus without TLC_EMERG_PREEMPT_EN -> timing identical to REQ-032.
